gpio_ctrl: RTL and testbench



---
 rtl/gpio_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gpio_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: N-pin GPIO controller on the SoC register-packet bus.
// Holds direction/output/interrupt configuration, synchronises the pads,
// latches level or edge interrupts per pin and raises one interrupt line.
module gpio_ctrl #(
  parameter int N  = 24,
  parameter int AW = 32,
  parameter int PW = 2*AW+40,
  parameter int ID = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          reg_access,
  input  logic [PW-1:0] reg_packet,
  input  logic [N-1:0]  gpio_in,
  output logic [31:0]   reg_rdata,
  output logic [N-1:0]  gpio_out,
  output logic [N-1:0]  gpio_en,
  output logic          gpio_irq,
  output logic [31:0]   gpio_ilat
);

  localparam logic [2:0] BLK_ID = 3'(ID);

  // Register indices (dstaddr[6:3])
  localparam logic [3:0] IDX_DIR     = 4'h0;
  localparam logic [3:0] IDX_IN      = 4'h1;
  localparam logic [3:0] IDX_OUT     = 4'h2;
  localparam logic [3:0] IDX_OUTCLR  = 4'h3;
  localparam logic [3:0] IDX_OUTSET  = 4'h4;
  localparam logic [3:0] IDX_OUTXOR  = 4'h5;
  localparam logic [3:0] IDX_IMASK   = 4'h6;
  localparam logic [3:0] IDX_ITYPE   = 4'h7;
  localparam logic [3:0] IDX_IPOL    = 4'h8;
  localparam logic [3:0] IDX_ILAT    = 4'h9;
  localparam logic [3:0] IDX_ILATCLR = 4'hA;

  // Zero-extend an N-bit pin vector to the 32-bit bus width.
  function automatic logic [31:0] zext32(input logic [N-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[N-1:0] = v;
    return r;
  endfunction

  // Packet fields
  logic [AW-1:0] dstaddr_s;
  logic [AW-1:0] wdata_s;
  logic [N-1:0]  data_s;
  logic [3:0]    idx_s;
  logic          sel_s;
  logic          wr_s;
  logic          rd_s;
  logic          unused_s;

  assign dstaddr_s = reg_packet[AW+7:8];
  assign wdata_s   = reg_packet[2*AW+7:AW+8];
  assign data_s    = wdata_s[N-1:0];
  assign idx_s     = dstaddr_s[6:3];
  assign sel_s     = reg_access & (dstaddr_s[10:8] == BLK_ID);
  assign wr_s      = sel_s & reg_packet[0];
  assign rd_s      = sel_s & ~reg_packet[0];

  // Ctrl, srcaddr and the unused address/data bits are deliberately ignored.
  assign unused_s = ^{reg_packet[7:1], reg_packet[PW-1:2*AW+8], dstaddr_s, wdata_s};

  // State
  logic [N-1:0] dir_q,   dir_d;
  logic [N-1:0] out_q,   out_d;
  logic [N-1:0] imask_q, imask_d;
  logic [N-1:0] itype_q, itype_d;
  logic [N-1:0] ipol_q,  ipol_d;
  logic [N-1:0] ilat_q,  ilat_d;
  logic [N-1:0] sync1_q, sync_q, prev_q;
  logic [31:0]  rdata_q, rdata_d;
  logic [N-1:0] ilat_clr_s;
  logic [N-1:0] ilat_set_s;
  logic [N-1:0] rd_sel_s;

  // Configuration register writes, including the OUT set/clear/toggle aliases.
  always_comb begin
    dir_d      = dir_q;
    out_d      = out_q;
    imask_d    = imask_q;
    itype_d    = itype_q;
    ipol_d     = ipol_q;
    ilat_clr_s = '0;
    if (wr_s) begin
      case (idx_s)
        IDX_DIR:     dir_d      = data_s;
        IDX_OUT:     out_d      = data_s;
        IDX_OUTCLR:  out_d      = out_q & ~data_s;
        IDX_OUTSET:  out_d      = out_q | data_s;
        IDX_OUTXOR:  out_d      = out_q ^ data_s;
        IDX_IMASK:   imask_d    = data_s;
        IDX_ITYPE:   itype_d    = data_s;
        IDX_IPOL:    ipol_d     = data_s;
        IDX_ILATCLR: ilat_clr_s = data_s;
        default:     ilat_clr_s = '0;
      endcase
    end else begin
      ilat_clr_s = '0;
    end
  end

  // Interrupt detection: level matches polarity, or edge into the polarity level;
  // a set in the same cycle as a clear takes precedence.
  always_comb begin
    ilat_set_s = ~(sync_q ^ ipol_q) & (~itype_q | (sync_q ^ prev_q));
    ilat_d     = (ilat_q & ~ilat_clr_s) | ilat_set_s;
  end

  // Read mux: load on a read access, otherwise hold the last read value.
  always_comb begin
    rd_sel_s = '0;
    rdata_d  = rdata_q;
    if (rd_s) begin
      case (idx_s)
        IDX_DIR:   rd_sel_s = dir_q;
        IDX_IN:    rd_sel_s = sync_q;
        IDX_OUT:   rd_sel_s = out_q;
        IDX_IMASK: rd_sel_s = imask_q;
        IDX_ITYPE: rd_sel_s = itype_q;
        IDX_IPOL:  rd_sel_s = ipol_q;
        IDX_ILAT:  rd_sel_s = ilat_q;
        default:   rd_sel_s = '0;
      endcase
      rdata_d = zext32(rd_sel_s);
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers with synchronous reset that overrides any access.
  always_ff @(posedge clk) begin
    if (nreset) begin
      dir_q   <= '0;
      out_q   <= '0;
      imask_q <= {N{1'b1}};
      itype_q <= '0;
      ipol_q  <= '0;
      ilat_q  <= '0;
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      rdata_q <= 32'd0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      imask_q <= imask_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      ilat_q  <= ilat_d;
      sync1_q <= gpio_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
      rdata_q <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_en   = dir_q;
  assign gpio_irq  = |(ilat_q & ~imask_q);
  assign gpio_ilat = zext32(ilat_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed self-checking bench for gpio_ctrl.
module tb_gpio_ctrl;

  localparam int N  = 24;
  localparam int AW = 32;
  localparam int PW = 2*AW+40;

  logic          clk;
  logic          nreset;
  logic          reg_access;
  logic [PW-1:0] reg_packet;
  logic [N-1:0]  gpio_in;
  logic [31:0]   reg_rdata;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_en;
  logic          gpio_irq;
  logic [31:0]   gpio_ilat;

  int n_checks;
  int n_fail;

  gpio_ctrl #(.N(N), .AW(AW), .PW(PW), .ID(0)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .reg_access (reg_access),
    .reg_packet (reg_packet),
    .gpio_in    (gpio_in),
    .reg_rdata  (reg_rdata),
    .gpio_out   (gpio_out),
    .gpio_en    (gpio_en),
    .gpio_irq   (gpio_irq),
    .gpio_ilat  (gpio_ilat)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkpkt(input logic wr, input logic [3:0] idx,
                                          input logic [2:0] id, input logic [31:0] data);
    logic [PW-1:0] p;
    p          = '0;
    p[0]       = wr;
    p[7:1]     = 7'h55;
    p[14:11]   = idx;
    p[18:16]   = id;
    p[71:40]   = data;
    p[103:72]  = 32'hDEADBEEF;
    return p;
  endfunction

  // One-cycle write; returns on the following negedge, after the update edge.
  task automatic bus_wr(input logic [3:0] idx, input logic [31:0] data, input logic [2:0] id);
    @(negedge clk);
    reg_access = 1'b1;
    reg_packet = mkpkt(1'b1, idx, id, data);
    @(negedge clk);
    reg_access = 1'b0;
    reg_packet = '0;
  endtask

  // One-cycle read; returns reg_rdata one cycle after the access.
  task automatic bus_rd(input logic [3:0] idx, input logic [2:0] id, output logic [31:0] data);
    @(negedge clk);
    reg_access = 1'b1;
    reg_packet = mkpkt(1'b0, idx, id, 32'hFFFFFFFF);
    @(negedge clk);
    reg_access = 1'b0;
    reg_packet = '0;
    data = reg_rdata;
  endtask

  logic [31:0] rd;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    nreset     = 1'b1;
    reg_access = 1'b0;
    reg_packet = '0;
    gpio_in    = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b0;
    chk("rst_out",   32'(gpio_out), 32'h00000000);
    chk("rst_en",    32'(gpio_en),  32'h00000000);
    chk("rst_irq",   32'(gpio_irq), 32'h00000000);
    chk("rst_ilat",  gpio_ilat,     32'h00000000);
    chk("rst_rdata", reg_rdata,     32'h00000000);
    bus_rd(4'h6, 3'd0, rd);
    chk("rst_imask", rd, 32'h00FFFFFF);

    // Output ops
    bus_wr(4'h0, 32'h000000FF, 3'd0);
    chk("dir_en", 32'(gpio_en), 32'h000000FF);
    bus_wr(4'h2, 32'hFF00A5A5, 3'd0);
    chk("out_wr", 32'(gpio_out), 32'h0000A5A5);
    bus_wr(4'h4, 32'h00000F00, 3'd0);
    chk("outset", 32'(gpio_out), 32'h0000AFA5);
    bus_wr(4'h3, 32'h000000A0, 3'd0);
    chk("outclr", 32'(gpio_out), 32'h0000AF05);
    bus_wr(4'h5, 32'h0000FFFF, 3'd0);
    chk("outxor", 32'(gpio_out), 32'h000050FA);
    bus_rd(4'h2, 3'd0, rd);
    chk("rd_out", rd, 32'h000050FA);
    bus_rd(4'h4, 3'd0, rd);
    chk("rd_wo", rd, 32'h00000000);
    // Default low-level mode latches every low pin, but all are masked
    chk("lvl_all_ilat", gpio_ilat, 32'h00FFFFFF);
    chk("lvl_all_irq", 32'(gpio_irq), 32'h00000000);

    // Input read
    @(negedge clk);
    gpio_in = 24'h000002;
    repeat (3) @(negedge clk);
    bus_rd(4'h1, 3'd0, rd);
    chk("rd_in", rd, 32'h00000002);

    // Rising-edge interrupt on pin 1: all pins edge/rising, clear latch
    bus_wr(4'h7, 32'h00FFFFFF, 3'd0);
    bus_wr(4'h8, 32'h00FFFFFF, 3'd0);
    bus_wr(4'hA, 32'h00FFFFFF, 3'd0);
    chk("ilat_clr_all", gpio_ilat, 32'h00000000);
    @(negedge clk);
    gpio_in = 24'h000000;
    repeat (4) @(negedge clk);
    chk("fall_no_lat", gpio_ilat, 32'h00000000);
    bus_wr(4'h6, 32'h00FFFFFD, 3'd0);
    gpio_in = 24'h000002;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("edge_k1_ilat", gpio_ilat, 32'h00000000);
    chk("edge_k1_irq", 32'(gpio_irq), 32'h00000000);
    @(posedge clk);
    #1;
    chk("edge_k2_ilat", gpio_ilat, 32'h00000002);
    chk("edge_k2_irq", 32'(gpio_irq), 32'h00000001);
    bus_wr(4'hA, 32'h00000002, 3'd0);
    chk("edge_clr_ilat", gpio_ilat, 32'h00000000);
    chk("edge_clr_irq", 32'(gpio_irq), 32'h00000000);
    repeat (3) @(negedge clk);
    chk("edge_no_relat", gpio_ilat, 32'h00000000);

    // Level interrupt on pin 3 (low level), others stay edge/rising
    bus_wr(4'h7, 32'h00FFFFF7, 3'd0);
    bus_wr(4'h8, 32'h00FFFFF7, 3'd0);
    bus_wr(4'h6, 32'h00FFFFF7, 3'd0);
    chk("lvl_ilat", gpio_ilat, 32'h00000008);
    chk("lvl_irq", 32'(gpio_irq), 32'h00000001);
    bus_wr(4'hA, 32'h00000008, 3'd0);
    chk("lvl_set_wins", gpio_ilat, 32'h00000008);
    chk("lvl_irq_hold", 32'(gpio_irq), 32'h00000001);
    bus_rd(4'h9, 3'd0, rd);
    chk("rd_ilat", rd, 32'h00000008);

    // Address / ID filter
    bus_wr(4'h2, 32'h00123456, 3'd1);
    chk("id_filter_out", 32'(gpio_out), 32'h000050FA);
    bus_rd(4'h2, 3'd0, rd);
    chk("rd_out2", rd, 32'h000050FA);
    bus_rd(4'h0, 3'd1, rd);
    chk("id_filter_rd_hold", rd, 32'h000050FA);
    bus_rd(4'hF, 3'd0, rd);
    chk("rd_idx_f", rd, 32'h00000000);

    // Reset overrides a concurrent write
    @(negedge clk);
    nreset     = 1'b1;
    reg_access = 1'b1;
    reg_packet = mkpkt(1'b1, 4'h2, 3'd0, 32'h00FFFFFF);
    @(negedge clk);
    reg_access = 1'b0;
    reg_packet = '0;
    chk("rst_ovr_out", 32'(gpio_out), 32'h00000000);
    chk("rst_ovr_en", 32'(gpio_en), 32'h00000000);
    nreset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
